// File: rtl/debug_snapshot_streamer.sv
// Purpose: latch a packed debug snapshot on a capture pulse and stream it as header, MSB-first data bytes, and an XOR checksum.
// Latency: first byte is valid 1 cycle after capture; with ready held high a frame of NBYTES+EN_HDR+EN_CKSUM bytes takes that many cycles.
// Backpressure: valid/ready; o_tx_data is held while valid and not ready. A capture while busy is dropped and flagged on o_overrun.
//
// Ports:
//   clk, i_reset       clock, asynchronous active-high reset
//   i_capture          1-cycle pulse: latch i_snapshot and start a frame (only honoured in IDLE)
//   i_snapshot         NB_SNAP-bit debug vector
//   i_clr_overrun      clears the sticky o_overrun flag
//   i_tx_ready         sink accepts o_tx_data this cycle
//   o_tx_data/valid    current byte and its valid
//   o_busy             frame in progress
//   o_done             1-cycle pulse the cycle after the last byte is accepted
//   o_overrun          sticky: capture arrived while busy
module debug_snapshot_streamer #(
    parameter int unsigned NB_SNAP  = 304,
    parameter int unsigned EN_HDR   = 1,
    parameter logic [7:0]  HDR_BYTE = 8'hA5,
    parameter int unsigned EN_CKSUM = 1
) (
    input  logic               clk,
    input  logic               i_reset,
    input  logic               i_capture,
    input  logic [NB_SNAP-1:0] i_snapshot,
    input  logic               i_clr_overrun,
    input  logic               i_tx_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_valid,
    output logic               o_busy,
    output logic               o_done,
    output logic               o_overrun
);

    localparam int unsigned NBYTES = NB_SNAP / 8;
    // One spare bit so the index can step past the last byte without wrapping.
    localparam int unsigned IDXW = $clog2(NBYTES) + 1;
    localparam logic [IDXW-1:0] LAST_IDX = IDXW'(NBYTES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HDR,
        DATA,
        CKS
    } state_t;

    state_t             state;
    state_t             stateNext;
    logic [NB_SNAP-1:0] snapReg;
    logic [IDXW-1:0]    byteIdx;
    logic [7:0]         cksum;
    logic [7:0]         dataByte;
    logic               startFrame;
    logic               frameEnd;

    // Every non-IDLE state presents a byte, so valid and busy are pure state decodes.
    assign o_tx_valid = (state != IDLE);
    assign o_busy     = (state != IDLE);

    // Byte idx counted from the most significant end of the snapshot.
    always_comb begin
        dataByte = 8'h00;
        for (int unsigned b = 0; b < NBYTES; b++) begin
            if (byteIdx == IDXW'(b)) begin
                dataByte = snapReg[8*(NBYTES-1-b) +: 8];
            end
        end
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            state <= IDLE;
        end else begin
            state <= stateNext;
        end
    end

    always_comb begin
        stateNext  = state;
        o_tx_data  = 8'h00;
        startFrame = 1'b0;
        frameEnd   = 1'b0;
        case (state)
            IDLE: begin
                if (i_capture) begin
                    startFrame = 1'b1;
                    stateNext  = (EN_HDR != 0) ? HDR : DATA;
                end
            end
            HDR: begin
                o_tx_data = HDR_BYTE;
                if (i_tx_ready) begin
                    stateNext = DATA;
                end
            end
            DATA: begin
                o_tx_data = dataByte;
                if (i_tx_ready && (byteIdx == LAST_IDX)) begin
                    if (EN_CKSUM != 0) begin
                        stateNext = CKS;
                    end else begin
                        stateNext = IDLE;
                        frameEnd  = 1'b1;
                    end
                end
            end
            CKS: begin
                o_tx_data = cksum;
                if (i_tx_ready) begin
                    stateNext = IDLE;
                    frameEnd  = 1'b1;
                end
            end
            default: begin
                stateNext = IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or posedge i_reset) begin
        if (i_reset) begin
            snapReg   <= '0;
            byteIdx   <= '0;
            cksum     <= 8'h00;
            o_done    <= 1'b0;
            o_overrun <= 1'b0;
        end else begin
            o_done <= frameEnd;

            if (startFrame) begin
                snapReg <= i_snapshot;
                cksum   <= 8'h00;
                byteIdx <= '0;
            end else if ((state == DATA) && i_tx_ready) begin
                cksum   <= cksum ^ dataByte;
                byteIdx <= byteIdx + IDXW'(1);
            end

            // A dropped capture must not be lost to a simultaneous clear.
            if (i_capture && (state != IDLE)) begin
                o_overrun <= 1'b1;
            end else if (i_clr_overrun) begin
                o_overrun <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_debug_snapshot_streamer.sv
module tb_debug_snapshot_streamer;

    logic clk = 1'b0;
    logic rst;
    always #5 clk = ~clk;

    // 32-bit instance, default framing
    logic        capA, clrA, rdyA;
    logic [31:0] snapA;
    logic [7:0]  datA;
    logic        vldA, busyA, doneA, ovrA;

    // 8-bit instance, no header, no checksum
    logic        capB, clrB, rdyB;
    logic [7:0]  snapB;
    logic [7:0]  datB;
    logic        vldB, busyB, doneB, ovrB;

    // default 304-bit instance
    logic         capC, clrC, rdyC;
    logic [303:0] snapC;
    logic [7:0]   datC;
    logic         vldC, busyC, doneC, ovrC;

    debug_snapshot_streamer #(.NB_SNAP(32)) dutA (
        .clk(clk), .i_reset(rst), .i_capture(capA), .i_snapshot(snapA),
        .i_clr_overrun(clrA), .i_tx_ready(rdyA), .o_tx_data(datA),
        .o_tx_valid(vldA), .o_busy(busyA), .o_done(doneA), .o_overrun(ovrA)
    );

    debug_snapshot_streamer #(.NB_SNAP(8), .EN_HDR(0), .EN_CKSUM(0)) dutB (
        .clk(clk), .i_reset(rst), .i_capture(capB), .i_snapshot(snapB),
        .i_clr_overrun(clrB), .i_tx_ready(rdyB), .o_tx_data(datB),
        .o_tx_valid(vldB), .o_busy(busyB), .o_done(doneB), .o_overrun(ovrB)
    );

    debug_snapshot_streamer dutC (
        .clk(clk), .i_reset(rst), .i_capture(capC), .i_snapshot(snapC),
        .i_clr_overrun(clrC), .i_tx_ready(rdyC), .o_tx_data(datC),
        .o_tx_valid(vldC), .o_busy(busyC), .o_done(doneC), .o_overrun(ovrC)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    // One row = inputs held for one cycle, plus the outputs expected during that cycle.
    typedef struct packed {
        logic        cap;
        logic [31:0] snap;
        logic        rdy;
        logic        clr;
        logic        vld;
        logic [7:0]  dat;
        logic        busy;
        logic        done;
        logic        ovr;
    } vec_t;

    localparam int NVEC = 18;
    vec_t vecs[NVEC];

    function automatic vec_t mk(logic cap, logic [31:0] snap, logic rdy, logic clr,
                                logic vld, logic [7:0] dat, logic busy, logic done, logic ovr);
        vec_t v;
        v.cap = cap; v.snap = snap; v.rdy = rdy; v.clr = clr;
        v.vld = vld; v.dat = dat; v.busy = busy; v.done = done; v.ovr = ovr;
        return v;
    endfunction

    initial begin
        #200000;
        $display("FAIL timeout: simulation did not finish, got running, expected finished");
        $fatal(1);
    end

    initial begin
        logic [7:0]   got[$];
        logic [7:0]   expA[6];
        logic [7:0]   expC[40];
        logic [303:0] patC;
        logic [303:0] tmp;
        logic [7:0]   x;
        logic [7:0]   prevDat;
        logic         stalledPrev;
        logic         doneSeen;
        int           cyc;

        // Frame 1: 12345678, checksum 12^34^56^78 = 08.
        vecs[0]  = mk(1, 32'h1234_5678, 1, 0,  0, 8'h00, 0, 0, 0);
        vecs[1]  = mk(0, 32'h0,         1, 0,  1, 8'hA5, 1, 0, 0);
        vecs[2]  = mk(0, 32'h0,         1, 0,  1, 8'h12, 1, 0, 0);
        vecs[3]  = mk(0, 32'h0,         1, 0,  1, 8'h34, 1, 0, 0);
        vecs[4]  = mk(0, 32'h0,         1, 0,  1, 8'h56, 1, 0, 0);
        vecs[5]  = mk(0, 32'h0,         1, 0,  1, 8'h78, 1, 0, 0);
        vecs[6]  = mk(0, 32'h0,         1, 0,  1, 8'h08, 1, 0, 0);
        // done cycle doubles as back-to-back capture of FFFFFFFF
        vecs[7]  = mk(1, 32'hFFFF_FFFF, 1, 0,  0, 8'h00, 0, 1, 0);
        vecs[8]  = mk(0, 32'h0,         1, 0,  1, 8'hA5, 1, 0, 0);
        // busy capture of 0: ignored, overrun next cycle
        vecs[9]  = mk(1, 32'h0,         1, 0,  1, 8'hFF, 1, 0, 0);
        vecs[10] = mk(0, 32'h0,         0, 0,  1, 8'hFF, 1, 0, 1);
        vecs[11] = mk(0, 32'h0,         1, 0,  1, 8'hFF, 1, 0, 1);
        vecs[12] = mk(0, 32'h0,         1, 0,  1, 8'hFF, 1, 0, 1);
        vecs[13] = mk(0, 32'h0,         1, 0,  1, 8'hFF, 1, 0, 1);
        vecs[14] = mk(0, 32'h0,         0, 0,  1, 8'h00, 1, 0, 1);
        vecs[15] = mk(0, 32'h0,         1, 1,  1, 8'h00, 1, 0, 1);
        vecs[16] = mk(0, 32'h0,         1, 0,  0, 8'h00, 0, 1, 0);
        vecs[17] = mk(0, 32'h0,         1, 0,  0, 8'h00, 0, 0, 0);

        expA[0] = 8'hA5; expA[1] = 8'h12; expA[2] = 8'h34;
        expA[3] = 8'h56; expA[4] = 8'h78; expA[5] = 8'h08;

        rst = 1'b1;
        capA = 0; clrA = 0; rdyA = 0; snapA = '0;
        capB = 0; clrB = 0; rdyB = 0; snapB = '0;
        capC = 0; clrC = 0; rdyC = 0; snapC = '0;
        #3;
        check("reset_A", {vldA, datA, busyA, doneA, ovrA}, 12'h0);
        check("reset_B", {vldB, datB, busyB, doneB, ovrB}, 12'h0);
        check("reset_C", {vldC, datC, busyC, doneC, ovrC}, 12'h0);
        @(negedge clk);
        rst = 1'b0;

        // Table: normal frame, back-to-back capture, overrun, stalls, clear.
        for (int i = 0; i < NVEC; i++) begin
            @(negedge clk);
            capA = vecs[i].cap; snapA = vecs[i].snap; rdyA = vecs[i].rdy; clrA = vecs[i].clr;
            #1;
            check($sformatf("vec%0d", i), {vldA, datA, busyA, doneA, ovrA},
                  {vecs[i].vld, vecs[i].dat, vecs[i].busy, vecs[i].done, vecs[i].ovr});
        end

        // Random ready: same bytes, data held across stalls.
        @(negedge clk);
        capA = 1; snapA = 32'h1234_5678; rdyA = 0;
        @(negedge clk);
        capA = 0;
        got.delete();
        stalledPrev = 0; prevDat = 8'h00; doneSeen = 0;
        for (int c = 0; c < 200 && !doneSeen; c++) begin
            rdyA = (c < 2) ? 1'b0 : 1'($urandom_range(0, 1));
            #1;
            if (vldA) begin
                if (stalledPrev) check("stall_hold", datA, prevDat);
                if (rdyA) got.push_back(datA);
                stalledPrev = !rdyA;
                prevDat = datA;
            end
            if (doneA) doneSeen = 1;
            @(negedge clk);
        end
        check("rand_done", doneSeen, 1);
        check("rand_len", got.size(), 6);
        for (int k = 0; k < 6 && k < got.size(); k++)
            check($sformatf("rand_byte%0d", k), got[k], expA[k]);
        rdyA = 1;

        // Busy capture and clear in the same cycle: set wins.
        @(negedge clk);
        capA = 1; snapA = 32'h0; rdyA = 0;
        @(negedge clk);
        capA = 1; clrA = 1;
        @(negedge clk);
        capA = 0; clrA = 0;
        #1;
        check("ovr_set_wins", ovrA, 1);
        @(negedge clk);
        clrA = 1;
        @(negedge clk);
        clrA = 0; rdyA = 1;
        #1;
        check("ovr_cleared", ovrA, 0);
        for (int c = 0; c < 20 && !doneA; c++) begin
            @(negedge clk);
            #1;
        end
        check("ovr_frame_done", doneA, 1);

        // Async reset after the third byte, then a fresh frame.
        @(negedge clk);
        capA = 1; snapA = 32'hAABB_CCDD; rdyA = 1;
        @(negedge clk);
        capA = 0;
        repeat (3) @(negedge clk);
        #1;
        check("pre_reset_byte", {vldA, datA}, {1'b1, 8'hCC});
        #1;
        rst = 1;
        #1;
        check("async_reset", {vldA, busyA, datA}, 10'h0);
        @(negedge clk);
        rst = 0;
        @(negedge clk);
        capA = 1; snapA = 32'h1122_3344;
        @(negedge clk);
        capA = 0;
        #1;
        check("post_reset_hdr", {vldA, datA}, {1'b1, 8'hA5});
        @(negedge clk);
        #1;
        check("post_reset_data0", {vldA, datA}, {1'b1, 8'h11});
        repeat (6) @(negedge clk);

        // 8-bit, no header/checksum: single byte then done.
        @(negedge clk);
        capB = 1; snapB = 8'h3C; rdyB = 1;
        #1;
        check("b_idle", busyB, 0);
        @(negedge clk);
        capB = 0;
        #1;
        check("b_byte", {vldB, datB, busyB}, {1'b1, 8'h3C, 1'b1});
        @(negedge clk);
        #1;
        check("b_done", {vldB, busyB, doneB}, 3'b001);
        @(negedge clk);
        #1;
        check("b_done_pulse", doneB, 0);
        capB = 1; snapB = 8'h5A; rdyB = 0;
        @(negedge clk);
        capB = 0;
        #1;
        check("b_stall0", {vldB, datB}, {1'b1, 8'h5A});
        @(negedge clk);
        rdyB = 1;
        #1;
        check("b_stall1", {vldB, datB}, {1'b1, 8'h5A});
        @(negedge clk);
        #1;
        check("b_stall_done", {vldB, doneB}, 2'b01);

        // 304-bit: capture in the done cycle of a previous frame.
        for (int k = 0; k < 38; k++) patC[8*k +: 8] = 8'(k * 37 + 11);
        tmp = patC;
        x = 8'h00;
        expC[0] = 8'hA5;
        for (int k = 0; k < 38; k++) begin
            expC[1 + k] = tmp[303:296];
            x = x ^ tmp[303:296];
            tmp = tmp << 8;
        end
        expC[39] = x;

        @(negedge clk);
        capC = 1; snapC = ~patC; rdyC = 1;
        @(negedge clk);
        capC = 0;
        #1;
        for (int c = 0; c < 60 && !doneC; c++) begin
            @(negedge clk);
            #1;
        end
        check("c_first_done", {doneC, busyC}, 2'b10);
        capC = 1; snapC = patC;
        @(negedge clk);
        capC = 0;
        #1;
        got.delete();
        cyc = 0;
        while (!doneC && cyc < 60) begin
            if (vldC) got.push_back(datC);
            cyc++;
            @(negedge clk);
            #1;
        end
        check("c_done", doneC, 1);
        check("c_cycles", cyc, 40);
        check("c_len", got.size(), 40);
        for (int k = 0; k < 40 && k < got.size(); k++)
            check($sformatf("c_byte%0d", k), got[k], expC[k]);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
